// File: rtl/rbus_d2r_pkg.sv
// Shared ctrl-word field positions, request entry type and grant encoder for the
// ring-bus device-to-ring grant manager.
package rbus_d2r_pkg;

   localparam int REQ_V   = 11;
   localparam int LONG    = 10;
   localparam int PRIO_HI = 9;
   localparam int PRIO_LO = 8;
   localparam int ID_W    = 8;
   localparam int CTRL_W  = 12;
   localparam int DATA_W  = 72;

   typedef struct packed {
      logic [ID_W-1:0] id;
   } req_t;

   function automatic logic [CTRL_W-1:0] grant_encode(input logic       long_cls,
                                                      input logic [1:0] prio,
                                                      input req_t       req);
      return {1'b1, long_cls, prio, req.id};
   endfunction

endpackage

// File: rtl/rbus_d2r_req_fifo.sv
// Request FIFO holding device ids for one (class, priority) queue.
module rbus_d2r_req_fifo
   import rbus_d2r_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  req_t                     din,
   output req_t                     dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   req_t              mem_r [DEPTH];
   logic [AW-1:0]     wr_ptr_r;
   logic [AW-1:0]     rd_ptr_r;
   logic [AW:0]       count_r;
   logic              do_push_s;
   logic              do_pop_s;

   assign full      = (count_r == (AW+1)'(DEPTH));
   assign empty     = (count_r == (AW+1)'(0));
   assign count     = count_r;
   assign dout      = mem_r[rd_ptr_r];
   assign do_push_s = push & ~full;
   assign do_pop_s  = pop & ~empty;

   // Entry storage; contents are don't-care while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_r[wr_ptr_r] <= din;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + (AW+1)'(1);
            2'b01:   count_r <= count_r - (AW+1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/rbus_d2r_mgr_prio.sv
// Device-to-ring grant manager: captures requests from data words into per-class,
// per-priority FIFOs and grants free header slots. Optional aging: RBUS_D2R_AGING_EN.
module rbus_d2r_mgr_prio
   import rbus_d2r_pkg::*;
#(
   parameter int PRIO_NUM   = 4,
   parameter int FIFO_DEPTH = 16,
   parameter int AGE_LIMIT  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_sof,
   input  logic [CTRL_W-1:0]     i_ctrl,
   input  logic [DATA_W-1:0]     i_data,
   output logic                  o_sof,
   output logic [CTRL_W-1:0]     o_ctrl,
   output logic [DATA_W-1:0]     o_data,
   output logic [2*PRIO_NUM-1:0] o_pending,
   output logic                  ff_err
);

   localparam int         NQ       = 2*PRIO_NUM;
   localparam int         CW       = $clog2(FIFO_DEPTH)+1;
   localparam logic [1:0] PRIO_MAX = 2'(PRIO_NUM-1);

   if (PRIO_NUM < 1 || PRIO_NUM > 4 || FIFO_DEPTH < 4 || FIFO_DEPTH > 64 ||
       (FIFO_DEPTH & (FIFO_DEPTH-1)) != 0 || AGE_LIMIT < 1) begin : g_cfg_err
      $error("rbus_d2r_mgr_prio: unsupported parameter set");
   end

   logic [NQ-1:0]     push_s;
   logic [NQ-1:0]     pop_s;
   logic [NQ-1:0]     full_s;
   logic [NQ-1:0]     empty_s;
   logic [CW-1:0]     count_s    [NQ];
   req_t              head_s     [NQ];
   req_t              din_s;
   logic              cls_s;
   logic [1:0]        req_prio_s;
   logic [PRIO_NUM-1:0] cls_empty_s;
   req_t              cls_head_s [PRIO_NUM];
   logic [1:0]        sel_s;
   logic              found_s;
   req_t              grant_id_s;
   logic              req_v_s;
   logic              req_full_s;
   logic              grant_v_s;
   logic [CTRL_W-1:0] ctrl_nxt_s;
   logic [NQ-1:0]     pend_nxt_s;

`ifdef RBUS_D2R_AGING_EN
   localparam int AGE_W = $clog2(AGE_LIMIT+1);
   logic [AGE_W-1:0] age_r [2][PRIO_NUM];
`endif

   assign din_s = req_t'(i_ctrl[ID_W-1:0]);

   for (genvar gi = 0; gi < NQ; gi++) begin : g_fifo
      rbus_d2r_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
         .clk   (clk),
         .rst   (rst),
         .push  (push_s[gi]),
         .pop   (pop_s[gi]),
         .din   (din_s),
         .dout  (head_s[gi]),
         .full  (full_s[gi]),
         .empty (empty_s[gi]),
         .count (count_s[gi])
      );
   end

   // Request decode, grant selection and next output word.
   always_comb begin
      cls_s      = i_ctrl[LONG];
      req_prio_s = (i_ctrl[PRIO_HI:PRIO_LO] > PRIO_MAX) ? PRIO_MAX : i_ctrl[PRIO_HI:PRIO_LO];
      sel_s      = 2'd0;
      found_s    = 1'b0;
      grant_id_s = '0;
      req_full_s = 1'b0;
      for (int p = 0; p < PRIO_NUM; p++) begin
         cls_empty_s[p] = cls_s ? empty_s[PRIO_NUM+p] : empty_s[p];
         cls_head_s[p]  = cls_s ? head_s[PRIO_NUM+p]  : head_s[p];
      end
      // Ascending scan: the last non-empty level seen is the highest.
      for (int p = 0; p < PRIO_NUM; p++) begin
         sel_s   = cls_empty_s[p] ? sel_s : 2'(p);
         found_s = found_s | ~cls_empty_s[p];
      end
`ifdef RBUS_D2R_AGING_EN
      // Descending scan so the lowest aged level overrides.
      for (int p = PRIO_NUM-2; p >= 0; p--) begin
         sel_s = ((age_r[cls_s][p] >= AGE_W'(AGE_LIMIT)) && !cls_empty_s[p]) ? 2'(p) : sel_s;
      end
`endif
      for (int p = 0; p < PRIO_NUM; p++) begin
         grant_id_s = (sel_s == 2'(p)) ? cls_head_s[p] : grant_id_s;
      end
      req_v_s   = ~i_sof & i_ctrl[REQ_V];
      grant_v_s = i_sof & i_ctrl[REQ_V] & found_s;
      for (int i = 0; i < NQ; i++) begin
         push_s[i]  = req_v_s & (cls_s == 1'(i / PRIO_NUM)) & (req_prio_s == 2'(i % PRIO_NUM)) & ~full_s[i];
         pop_s[i]   = grant_v_s & (cls_s == 1'(i / PRIO_NUM)) & (sel_s == 2'(i % PRIO_NUM));
         req_full_s = req_full_s | (req_v_s & (cls_s == 1'(i / PRIO_NUM)) &
                                    (req_prio_s == 2'(i % PRIO_NUM)) & full_s[i]);
         pend_nxt_s[i] = push_s[i] | (~empty_s[i] & ~(pop_s[i] & (count_s[i] == CW'(1))));
      end
      case ({i_sof, i_ctrl[REQ_V]})
         2'b01:   ctrl_nxt_s = req_full_s ? i_ctrl : 12'd0;
         2'b11:   ctrl_nxt_s = found_s ? grant_encode(cls_s, sel_s, grant_id_s) : i_ctrl;
         default: ctrl_nxt_s = i_ctrl;
      endcase
   end

   // Output register stage; ff_err is sticky until reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         o_sof     <= 1'b0;
         o_ctrl    <= 12'd0;
         o_data    <= 72'd0;
         o_pending <= '0;
         ff_err    <= 1'b0;
      end else begin
         o_sof     <= i_sof;
         o_ctrl    <= ctrl_nxt_s;
         o_data    <= i_data;
         o_pending <= pend_nxt_s;
         ff_err    <= ff_err | req_full_s;
      end
   end

`ifdef RBUS_D2R_AGING_EN
   // Bypass counters for every level below the top, per class.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int c = 0; c < 2; c++) begin
            for (int p = 0; p < PRIO_NUM; p++) begin
               age_r[c][p] <= '0;
            end
         end
      end else begin
         for (int c = 0; c < 2; c++) begin
            for (int p = 0; p < PRIO_NUM-1; p++) begin
               if (empty_s[c*PRIO_NUM+p]) begin
                  age_r[c][p] <= '0;
               end else if (grant_v_s && (cls_s == 1'(c))) begin
                  if (sel_s == 2'(p)) begin
                     age_r[c][p] <= '0;
                  end else if ((sel_s > 2'(p)) && (age_r[c][p] < AGE_W'(AGE_LIMIT))) begin
                     age_r[c][p] <= age_r[c][p] + AGE_W'(1);
                  end
               end
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_rbus_d2r_mgr_prio.sv
// Directed bench for rbus_d2r_mgr_prio: vector table plus FIFO-full, reset-discard
// and aging sequences (aging expectations follow RBUS_D2R_AGING_EN).
module tb_rbus_d2r_mgr_prio;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_sof;
   logic [11:0] i_ctrl;
   logic [71:0] i_data;
   logic        o_sof;
   logic [11:0] o_ctrl;
   logic [71:0] o_data;
   logic [7:0]  o_pending;
   logic        ff_err;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic        sof;
      logic [11:0] ctrl;
      logic [11:0] exp_ctrl;
      logic [7:0]  exp_pend;
      logic        exp_err;
   } vec_t;

   vec_t vecs [19];

   rbus_d2r_mgr_prio #(.PRIO_NUM(4), .FIFO_DEPTH(16), .AGE_LIMIT(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .i_sof     (i_sof),
      .i_ctrl    (i_ctrl),
      .i_data    (i_data),
      .o_sof     (o_sof),
      .o_ctrl    (o_ctrl),
      .o_data    (o_data),
      .o_pending (o_pending),
      .ff_err    (ff_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic step(input logic sof, input logic [11:0] ctrl, input logic [11:0] ec,
                       input logic [7:0] ep, input logic ee, input string name);
      logic [71:0] d;
      d      = {$urandom(), $urandom(), 8'($urandom())};
      i_sof  = sof;
      i_ctrl = ctrl;
      i_data = d;
      @(posedge clk);
      #1;
      chk({name, ".ctrl"}, 72'(o_ctrl), 72'(ec));
      chk({name, ".pend"}, 72'(o_pending), 72'(ep));
      chk({name, ".err"}, 72'(ff_err), 72'(ee));
      chk({name, ".sof"}, 72'(o_sof), 72'(sof));
      chk({name, ".data"}, o_data, d);
   endtask

   task automatic reset_cycle(input string name);
      rst    = 1'b1;
      i_sof  = 1'b1;
      i_ctrl = 12'h800;
      i_data = {72{1'b1}};
      @(posedge clk);
      #1;
      chk({name, ".ctrl"}, 72'(o_ctrl), 72'd0);
      chk({name, ".pend"}, 72'(o_pending), 72'd0);
      chk({name, ".err"}, 72'(ff_err), 72'd0);
      chk({name, ".sof"}, 72'(o_sof), 72'd0);
      chk({name, ".data"}, o_data, 72'd0);
      rst = 1'b0;
   endtask

   initial begin
      vecs[0]  = '{1'b0, 12'h000, 12'h000, 8'h00, 1'b0};
      vecs[1]  = '{1'b0, 12'h000, 12'h000, 8'h00, 1'b0};
      vecs[2]  = '{1'b0, 12'hE25, 12'h000, 8'h40, 1'b0};
      vecs[3]  = '{1'b1, 12'hC00, 12'hE25, 8'h00, 1'b0};
      vecs[4]  = '{1'b0, 12'h811, 12'h000, 8'h01, 1'b0};
      vecs[5]  = '{1'b0, 12'hB33, 12'h000, 8'h09, 1'b0};
      vecs[6]  = '{1'b0, 12'hB34, 12'h000, 8'h09, 1'b0};
      vecs[7]  = '{1'b1, 12'h800, 12'hB33, 8'h09, 1'b0};
      vecs[8]  = '{1'b1, 12'hC00, 12'hC00, 8'h09, 1'b0};
      vecs[9]  = '{1'b1, 12'h800, 12'hB34, 8'h01, 1'b0};
      vecs[10] = '{1'b1, 12'h800, 12'h811, 8'h00, 1'b0};
      vecs[11] = '{1'b1, 12'h800, 12'h800, 8'h00, 1'b0};
      vecs[12] = '{1'b0, 12'hD07, 12'h000, 8'h20, 1'b0};
      vecs[13] = '{1'b1, 12'h400, 12'h400, 8'h20, 1'b0};
      vecs[14] = '{1'b1, 12'h3AB, 12'h3AB, 8'h20, 1'b0};
      vecs[15] = '{1'b0, 12'h123, 12'h123, 8'h20, 1'b0};
      vecs[16] = '{1'b1, 12'h800, 12'h800, 8'h20, 1'b0};
      vecs[17] = '{1'b1, 12'hC00, 12'hD07, 8'h00, 1'b0};
      vecs[18] = '{1'b1, 12'hC00, 12'hC00, 8'h00, 1'b0};

      reset_cycle("rst0");
      reset_cycle("rst1");

      for (int i = 0; i < 19; i++) begin
         step(vecs[i].sof, vecs[i].ctrl, vecs[i].exp_ctrl, vecs[i].exp_pend,
              vecs[i].exp_err, $sformatf("v%0d", i));
      end

      // Fill short prio-1 FIFO, overflow once, then drain in capture order.
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 12'h900 | 12'(i), 12'h000, 8'h02, 1'b0, $sformatf("fill%0d", i));
      end
      step(1'b0, 12'h910, 12'h910, 8'h02, 1'b1, "overflow");
      for (int i = 0; i < 16; i++) begin
         step(1'b1, 12'h800, 12'h900 | 12'(i), (i == 15) ? 8'h00 : 8'h02, 1'b1,
              $sformatf("drain%0d", i));
      end
      step(1'b1, 12'h800, 12'h800, 8'h00, 1'b1, "drained");

      // Queued request is discarded by a mid-run reset.
      step(1'b0, 12'hB55, 12'h000, 8'h08, 1'b1, "pre_rst");
      reset_cycle("rst_mid");
      step(1'b1, 12'h800, 12'h800, 8'h00, 1'b0, "post_rst");

      // Aging: prio-0 against a steady supply of prio-3 requests.
      step(1'b0, 12'h801, 12'h000, 8'h01, 1'b0, "age_p0");
      step(1'b0, 12'hB30, 12'h000, 8'h09, 1'b0, "age_p3a");
      step(1'b0, 12'hB31, 12'h000, 8'h09, 1'b0, "age_p3b");
      step(1'b1, 12'h800, 12'hB30, 8'h09, 1'b0, "age_g1");
      step(1'b0, 12'hB32, 12'h000, 8'h09, 1'b0, "age_p3c");
      step(1'b1, 12'h800, 12'hB31, 8'h09, 1'b0, "age_g2");
      step(1'b0, 12'hB33, 12'h000, 8'h09, 1'b0, "age_p3d");
`ifdef RBUS_D2R_AGING_EN
      step(1'b1, 12'h800, 12'h801, 8'h08, 1'b0, "age_g3");
      step(1'b0, 12'hB34, 12'h000, 8'h08, 1'b0, "age_p3e");
      step(1'b1, 12'h800, 12'hB32, 8'h08, 1'b0, "age_g4");
`else
      step(1'b1, 12'h800, 12'hB32, 8'h09, 1'b0, "age_g3");
      step(1'b0, 12'hB34, 12'h000, 8'h09, 1'b0, "age_p3e");
      step(1'b1, 12'h800, 12'hB33, 8'h09, 1'b0, "age_g4");
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rbus_d2r_mgr_prio.md
Name: rbus_d2r_mgr_prio

Overview:
Parametrised next-generation device-to-ring grant manager for one ring bus. It captures device requests travelling with data words. It queues them per packet class (long/short) and per priority level. It answers each free header slot with a grant to the oldest request of the highest non-empty priority. A multi-bus wrapper instantiates it once per bus and ORs ff_err.

Parameters:
PRIO_NUM, 4, number of priority levels (1..4); level PRIO_NUM-1 highest, 0 lowest
FIFO_DEPTH, 16, requests per FIFO; power of two, 4..64
AGE_LIMIT, 8, consecutive bypasses before a pending lower level is promoted (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
i_sof  in  1  1 = header word, 0 = data word
i_ctrl  in  12  data word: [11] req valid, [10] long(1)/short(0), [9:8] prio, [7:0] device id; header word: [11] slot free, [10] slot long/short
i_data  in  72  ring payload
o_sof  out  1  registered i_sof
o_ctrl  out  12  data word: request field, cleared if the request was captured; header word: grant or passthrough
o_data  out  72  registered i_data, never modified
o_pending  out  2*PRIO_NUM  non-empty flags; [PRIO_NUM-1:0] short FIFOs, upper half long FIFOs
ff_err  out  1  sticky: a request was skipped because its FIFO was full

Behaviour:
- Pipeline and reset
  - Single register stage: every output is valid 1 cycle after the input.
  - o_data is always i_data delayed by 1 cycle.
  - Reset values: o_sof=0, o_ctrl=0, o_data=0, o_pending=0, ff_err=0. All FIFOs are emptied.
  - Reset asserted mid-operation discards queued requests. The word present during the reset cycle is dropped; its output is 0.
- Data word (i_sof=0) with i_ctrl[11]=1
  - Priority index p = i_ctrl[9:8]. If p >= PRIO_NUM, it is clamped to PRIO_NUM-1.
  - If FIFO(class, p) is not full: push {id}, and output o_ctrl=0 (request consumed).
  - If the FIFO is full: o_ctrl=i_ctrl unchanged (the request stays on the ring) and ff_err is set. ff_err clears only on rst.
- Data word with i_ctrl[11]=0: passthrough.
- Header word (i_sof=1) with i_ctrl[11]=1 (free slot)
  - Candidate set: FIFOs of class i_ctrl[10] only. Short requests never take long slots, and long requests never take short slots.
  - Select the highest non-empty priority and pop its head.
  - o_ctrl = {1, class, prio[1:0], id}.
  - If no candidate exists: o_ctrl = i_ctrl (slot stays free).
- Header word with i_ctrl[11]=0 (occupied): passthrough.
- Push and pop are never in the same cycle, because they occur on different word types. Full/empty flags therefore need no bypass.
- A request that enters on a data word can be granted at the earliest on the next header word, at least 1 cycle later.
- Within one FIFO, grant order equals capture order.
- FIFO counters are ceil(log2(FIFO_DEPTH))+1 bits. Pointers wrap modulo FIFO_DEPTH.
- o_pending is registered. It reflects FIFO state after the current cycle's push/pop.

Optional Feature:
Macro RBUS_D2R_AGING_EN.
- With the macro: each class keeps one bypass counter per level below the top.
  - A counter increments when its level is non-empty and a grant in that class goes to a higher level.
  - It clears when its level is granted or becomes empty.
  - When a counter reaches AGE_LIMIT, that level wins the next free slot of its class regardless of priority. Among aged levels, the lowest wins. The counter then clears.
  - The grant o_ctrl[9:8] carries the original level.
- Without the macro: strict priority; counters are absent.

Decomposition:
- Package rbus_d2r_pkg holds:
  - ctrl field bit positions: REQ_V=11, LONG=10, PRIO_HI=9, PRIO_LO=8, ID width 8
  - a request struct {id}
  - a grant encode function
- One sub-module: rbus_d2r_req_fifo (parametrised depth, 8-bit entries, push/pop/full/empty/count).
  - Instantiated 2*PRIO_NUM times in a generate loop.
- Grant selection is a combinational priority encoder in the top module.

Test Plan:
- Reset, then idle data words i_ctrl=0x000 -> outputs echo inputs 1 cycle later; o_pending=0; ff_err=0.
- Data req i_ctrl=0xE25 (long, prio 2, id 0x25), then free long header i_ctrl=0xC00 -> data o_ctrl=0x000; header o_ctrl=0xE25; o_pending long bit 2 rises then falls.
- Short reqs prio 0 id 0x11, prio 3 id 0x33, prio 3 id 0x34, then 3 free short headers 0x800 -> grants 0xB33, 0xB34, 0x811 in that order. A free long header 0xC00 in between passes as 0xC00.
- 17 short prio-1 reqs, FIFO_DEPTH=16 -> first 16 cleared. The 17th exits with o_ctrl=0x9xx unchanged; ff_err=1 and stays 1 until rst.
- Occupied header i_ctrl=0x400 with pending long req -> o_ctrl=0x400; request stays queued.
- With RBUS_D2R_AGING_EN, AGE_LIMIT=2: constant supply of short prio-3 reqs plus one prio-0 req -> the prio-0 request is granted on the 3rd free short header. Without the macro it is never granted while prio-3 remains non-empty.
